// File: rtl/cpu_pkg.sv
// Shared predictor types: 2-bit counter encodings, predictor modes and the
// BTB entry layout.
package cpu_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam int MODE_STATIC  = 0;
  localparam int MODE_BIMODAL = 1;

  // The entry layout is sized for the default geometry; the top defaults its
  // PC_W/IDX_W parameters to these values.
  localparam int BTB_PC_W  = 32;
  localparam int BTB_IDX_W = 4;
  localparam int BTB_TAG_W = BTB_PC_W - BTB_IDX_W - 2;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_PC_W-1:0]  target;
    logic [1:0]           ctr;
  } bpe_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Next-state step of a 2-bit saturating up/down direction counter.
module sat_counter2
  import cpu_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       up,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (up) begin
      if (ctr != ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with bimodal counters: zero-latency IF lookup, EX-stage
// resolve/update with mispredict redirect, and saturating statistics.
module branch_predictor_btb
  import cpu_pkg::*;
#(
  parameter int PC_W  = BTB_PC_W,
  parameter int IDX_W = BTB_IDX_W,
  parameter int MODE  = MODE_BIMODAL,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [PC_W-1:0]  ex_pred_target,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispred
);

  localparam int ENTRIES = 2 ** IDX_W;

  bpe_entry_t btb_mem [ENTRIES];

  logic [IDX_W-1:0]     if_idx;
  logic [BTB_TAG_W-1:0] if_tag;
  logic                 if_hit;
  logic [IDX_W-1:0]     ex_idx;
  logic [BTB_TAG_W-1:0] ex_tag;
  logic                 ex_hit;
  logic [1:0]           ctr_next;
  logic [CNT_W-1:0]     stat_branches_reg;
  logic [CNT_W-1:0]     stat_mispred_reg;

  // IF lookup reads the pre-edge table; a same-cycle EX write is not bypassed.
  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign if_hit = btb_mem[if_idx].valid && (btb_mem[if_idx].tag == if_tag);

  assign pred_taken  = (MODE == MODE_BIMODAL) && if_hit && btb_mem[if_idx].ctr[1];
  assign pred_target = pred_taken ? btb_mem[if_idx].target : if_pc + PC_W'(4);

  assign mispredict  = ex_valid &&
                       ((ex_taken != ex_pred_taken) ||
                        (ex_taken && (ex_pred_target != ex_target)));
  assign redirect_pc = ex_taken ? ex_target : ex_pc + PC_W'(4);

  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+2];
  assign ex_hit = btb_mem[ex_idx].valid && (btb_mem[ex_idx].tag == ex_tag);

  sat_counter2 u_ctr_step (
    .ctr      (btb_mem[ex_idx].ctr),
    .up       (ex_taken),
    .ctr_next (ctr_next)
  );

  // A taken miss evicts whatever occupies the slot; a not-taken miss is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
    end else if (ex_valid) begin
      if (ex_hit) begin
        btb_mem[ex_idx].ctr <= ctr_next;
        if (ex_taken) btb_mem[ex_idx].target <= ex_target;
      end else if (ex_taken) begin
        btb_mem[ex_idx] <= '{valid: 1'b1, tag: ex_tag, target: ex_target, ctr: WT};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_branches_reg <= '0;
      stat_mispred_reg  <= '0;
    end else if (ex_valid) begin
      if (stat_branches_reg != '1) stat_branches_reg <= stat_branches_reg + CNT_W'(1);
      if (mispredict && (stat_mispred_reg != '1)) stat_mispred_reg <= stat_mispred_reg + CNT_W'(1);
    end
  end

  assign stat_branches = stat_branches_reg;
  assign stat_mispred  = stat_mispred_reg;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench: a bimodal 16-bit-stat predictor and a static 4-bit-stat
// predictor share stimulus; a negedge monitor checks queued expectations.
module tb_branch_predictor_btb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] if_pc, ex_pc, ex_target, ex_pred_target;
  logic        ex_valid, ex_taken, ex_pred_taken;

  logic        pred_taken, mispredict;
  logic [31:0] pred_target, redirect_pc;
  logic [15:0] stat_branches, stat_mispred;

  logic        s_pred_taken, s_mispredict;
  logic [31:0] s_pred_target, s_redirect_pc;
  logic [3:0]  s_stat_branches, s_stat_mispred;

  branch_predictor_btb #(.PC_W(32), .IDX_W(4), .MODE(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  branch_predictor_btb #(.PC_W(32), .IDX_W(4), .MODE(0), .CNT_W(4)) dut_static (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(s_pred_taken), .pred_target(s_pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(s_mispredict), .redirect_pc(s_redirect_pc),
    .stat_branches(s_stat_branches), .stat_mispred(s_stat_mispred)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        mp;
    logic [31:0] rpc;
    int          sb;
    int          sm;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] sat4(input int v);
    return (v > 15) ? 32'd15 : 32'(v);
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.name, ".pred_taken"},   32'(pred_taken),     32'(e.pt));
        chk({e.name, ".pred_target"},  pred_target,         e.ptgt);
        chk({e.name, ".mispredict"},   32'(mispredict),     32'(e.mp));
        chk({e.name, ".redirect_pc"},  redirect_pc,         e.rpc);
        chk({e.name, ".stat_br"},      32'(stat_branches),  32'(e.sb));
        chk({e.name, ".stat_mis"},     32'(stat_mispred),   32'(e.sm));
        chk({e.name, ".s_pred_taken"}, 32'(s_pred_taken),   32'd0);
        chk({e.name, ".s_pred_tgt"},   s_pred_target,       e.pc + 32'd4);
        chk({e.name, ".s_mispredict"}, 32'(s_mispredict),   32'(e.mp));
        chk({e.name, ".s_redirect"},   s_redirect_pc,       e.rpc);
        chk({e.name, ".s_stat_br"},    32'(s_stat_branches), sat4(e.sb));
        chk({e.name, ".s_stat_mis"},   32'(s_stat_mispred),  sat4(e.sm));
        $display("txn %-12s if_pc=%h pt=%0b tgt=%h mp=%0b rpc=%h br=%0d mis=%0d",
                 e.name, e.pc, pred_taken, pred_target, mispredict, redirect_pc,
                 stat_branches, stat_mispred);
      end
    end
  end

  task automatic drive(input string name, input logic rst, input logic [31:0] pc,
                       input logic v, input logic [31:0] xpc, input logic xt,
                       input logic [31:0] xtgt, input logic xpt, input logic [31:0] xptgt,
                       input logic e_pt, input logic [31:0] e_ptgt, input logic e_mp,
                       input logic [31:0] e_rpc, input int e_sb, input int e_sm);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; if_pc = pc; ex_valid = v; ex_pc = xpc; ex_taken = xt;
    ex_target = xtgt; ex_pred_taken = xpt; ex_pred_target = xptgt;
    e.name = name; e.pc = pc; e.pt = e_pt; e.ptgt = e_ptgt; e.mp = e_mp;
    e.rpc = e_rpc; e.sb = e_sb; e.sm = e_sm;
    sb_q.push_back(e);
  endtask

  task automatic bubble(input string name, input logic rst, input logic [31:0] pc,
                        input logic e_pt, input logic [31:0] e_ptgt, input int e_sb, input int e_sm);
    drive(name, rst, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
          e_pt, e_ptgt, 1'b0, 32'h4, e_sb, e_sm);
  endtask

  initial begin
    reset = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0;
    ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    bubble("reset_state", 1'b1, 32'h00400000, 1'b0, 32'h00400004, 0, 0);
    drive ("alloc",       1'b1, 32'h00400010, 1'b1, 32'h00400010, 1'b1, 32'h00400040, 1'b0, 32'h00400014,
           1'b0, 32'h00400014, 1'b1, 32'h00400040, 0, 0);
    bubble("hit_taken",   1'b1, 32'h00400010, 1'b1, 32'h00400040, 1, 1);
    drive ("nt_first",    1'b1, 32'h00400010, 1'b1, 32'h00400010, 1'b0, 32'h00400040, 1'b1, 32'h00400040,
           1'b1, 32'h00400040, 1'b1, 32'h00400014, 1, 1);
    drive ("nt_second",   1'b1, 32'h00400010, 1'b1, 32'h00400010, 1'b0, 32'h00400040, 1'b0, 32'h00400014,
           1'b0, 32'h00400014, 1'b0, 32'h00400014, 2, 2);
    bubble("ctr_snt",     1'b1, 32'h00400010, 1'b0, 32'h00400014, 3, 2);
    drive ("retarget",    1'b1, 32'h00400010, 1'b1, 32'h00400010, 1'b1, 32'h00400080, 1'b0, 32'h00400014,
           1'b0, 32'h00400014, 1'b1, 32'h00400080, 3, 2);
    drive ("ctr_wnt_tk",  1'b1, 32'h00400010, 1'b1, 32'h00400010, 1'b1, 32'h00400080, 1'b0, 32'h00400014,
           1'b0, 32'h00400014, 1'b1, 32'h00400080, 4, 3);
    bubble("new_target",  1'b1, 32'h00400010, 1'b1, 32'h00400080, 5, 4);
    drive ("correct",     1'b1, 32'h00400010, 1'b1, 32'h00400010, 1'b1, 32'h00400080, 1'b1, 32'h00400080,
           1'b1, 32'h00400080, 1'b0, 32'h00400080, 5, 4);
    drive ("bad_target",  1'b1, 32'h00400010, 1'b1, 32'h00400010, 1'b1, 32'h00400080, 1'b1, 32'h00400040,
           1'b1, 32'h00400080, 1'b1, 32'h00400080, 6, 4);
    drive ("alias",       1'b1, 32'h00400010, 1'b1, 32'h00400050, 1'b1, 32'h00400100, 1'b0, 32'h00400054,
           1'b1, 32'h00400080, 1'b1, 32'h00400100, 7, 5);
    bubble("alias_miss",  1'b1, 32'h00400010, 1'b0, 32'h00400014, 8, 6);
    bubble("alias_hit",   1'b1, 32'h00400050, 1'b1, 32'h00400100, 8, 6);
    drive ("nt_no_alloc", 1'b1, 32'h00400020, 1'b1, 32'h00400020, 1'b0, 32'h00000000, 1'b0, 32'h00400024,
           1'b0, 32'h00400024, 1'b0, 32'h00400024, 8, 6);
    bubble("nt_still_ms", 1'b1, 32'h00400020, 1'b0, 32'h00400024, 9, 6);
    drive ("pc_wrap",     1'b1, 32'hFFFFFFFC, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h00000000, 1'b0, 32'h00000000,
           1'b0, 32'h00000000, 1'b0, 32'h00000000, 9, 6);

    // Mispredicted not-taken branches drive the 4-bit counters into saturation.
    for (int k = 0; k < 11; k++) begin
      drive("sat_loop", 1'b1, 32'h00400030, 1'b1, 32'h00400030, 1'b0, 32'h00000000, 1'b1, 32'h00400040,
            1'b0, 32'h00400034, 1'b1, 32'h00400034, 10 + k, 6 + k);
    end
    bubble("sat_hold",    1'b1, 32'h00400050, 1'b1, 32'h00400100, 21, 17);
    bubble("mid_reset",   1'b0, 32'h00400050, 1'b0, 32'h00400054, 0, 0);
    bubble("post_reset",  1'b1, 32'h00400050, 1'b0, 32'h00400054, 0, 0);
    drive ("realloc",     1'b1, 32'h00400010, 1'b1, 32'h00400010, 1'b1, 32'h00400040, 1'b0, 32'h00400014,
           1'b0, 32'h00400014, 1'b1, 32'h00400040, 0, 0);
    bubble("realloc_hit", 1'b1, 32'h00400010, 1'b1, 32'h00400040, 1, 1);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
